keypad_scan_ctrl: RTL

Scanning controller for the 4x4 launchpad keypad. Drives one active-low column strobe at a time, synchronizes and debounces the active-low row sense lines, and presents a stable 2-bit row/column index pair to the keypad decoder, which maps it to the 4-bit key value. A press is reported once per physical press through a valid/ack handshake with the consumer. Release detection and an overrun flag cover presses the consumer does not take in time.

---
 rtl/keypad_scan_if.sv | 20 ++
 rtl/keypad_scan_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_if.sv
// Key report channel between the keypad scanner and its consumer.
// The scanner drives the captured key and status; the consumer returns key_ack.
interface keypad_scan_if;
    logic [1:0] key_row;
    logic [1:0] key_col;
    logic       key_valid;
    logic       key_ack;
    logic       key_held;
    logic       overrun;

    modport master (
        output key_row, key_col, key_valid, key_held, overrun,
        input  key_ack
    );

    modport slave (
        input  key_row, key_col, key_valid, key_held, overrun,
        output key_ack
    );
endinterface

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: strobes one column at a time, debounces the selected row and
// reports each press once over a valid/ack channel, with release and overrun tracking.
module keypad_scan_ctrl #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 20000
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [3:0]    i_rows_n,
    output logic [3:0]    o_col_drive_n,
    keypad_scan_if.master kif
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(DEBOUNCE_CNT);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] DEB_LAST   = BW'(DEBOUNCE_CNT - 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

    state_t        r_state, w_state_nxt;
    logic [3:0]    r_sync1, r_rs;
    logic [DW-1:0] r_dwell, w_dwell_nxt;
    logic [BW-1:0] r_deb, w_deb_nxt;
    logic [1:0]    r_cur_col, w_col_nxt;
    logic [1:0]    r_cap_row, w_cap_row_nxt;
    logic [1:0]    r_cap_col, w_cap_col_nxt;
    logic [3:0]    r_col_drive_n;
    logic [1:0]    r_key_row, w_key_row_nxt;
    logic [1:0]    r_key_col, w_key_col_nxt;
    logic          r_key_valid, w_key_valid_nxt;
    logic          r_key_held, w_key_held_nxt;
    logic          r_overrun, w_overrun_nxt;
    logic          w_accept;

    function automatic logic [1:0] lowest_low(input logic [3:0] v);
        lowest_low = 2'd0;
        for (int i = 3; i >= 0; i--)
            if (!v[i]) lowest_low = 2'(i);
    endfunction

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1       <= 4'b1111;
            r_rs          <= 4'b1111;
            r_state       <= SCAN;
            r_dwell       <= '0;
            r_deb         <= '0;
            r_cur_col     <= 2'd0;
            r_cap_row     <= 2'd0;
            r_cap_col     <= 2'd0;
            r_col_drive_n <= 4'b1110;
            r_key_row     <= 2'd0;
            r_key_col     <= 2'd0;
            r_key_valid   <= 1'b0;
            r_key_held    <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_sync1       <= i_rows_n;
            r_rs          <= r_sync1;
            r_state       <= w_state_nxt;
            r_dwell       <= w_dwell_nxt;
            r_deb         <= w_deb_nxt;
            r_cur_col     <= w_col_nxt;
            r_cap_row     <= w_cap_row_nxt;
            r_cap_col     <= w_cap_col_nxt;
            // Strobe decoded from the next column so the pin is a flop output.
            r_col_drive_n <= ~(4'b0001 << w_col_nxt);
            r_key_row     <= w_key_row_nxt;
            r_key_col     <= w_key_col_nxt;
            r_key_valid   <= w_key_valid_nxt;
            r_key_held    <= w_key_held_nxt;
            r_overrun     <= w_overrun_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_dwell_nxt     = r_dwell;
        w_deb_nxt       = r_deb;
        w_col_nxt       = r_cur_col;
        w_cap_row_nxt   = r_cap_row;
        w_cap_col_nxt   = r_cap_col;
        w_key_row_nxt   = r_key_row;
        w_key_col_nxt   = r_key_col;
        w_key_valid_nxt = r_key_valid;
        w_key_held_nxt  = r_key_held;
        w_overrun_nxt   = r_overrun;
        w_accept        = 1'b0;

        case (r_state)
            SCAN: begin
                if (r_dwell == DWELL_LAST) begin
                    w_dwell_nxt = '0;
                    if (r_rs != 4'b1111) begin
                        w_cap_row_nxt = lowest_low(r_rs);
                        w_cap_col_nxt = r_cur_col;
                        w_deb_nxt     = '0;
                        w_state_nxt   = DEBOUNCE;
                    end else begin
                        w_col_nxt = r_cur_col + 2'd1;
                    end
                end else begin
                    w_dwell_nxt = r_dwell + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (!r_rs[r_cap_row]) begin
                    if (r_deb == DEB_LAST) begin
                        w_accept    = 1'b1;
                        w_deb_nxt   = '0;
                        w_state_nxt = HELD;
                    end else begin
                        w_deb_nxt = r_deb + 1'b1;
                    end
                end else begin
                    w_dwell_nxt = '0;
                    w_state_nxt = SCAN;
                end
            end
            HELD: begin
                if (r_rs[r_cap_row]) begin
                    if (r_deb == DEB_LAST) begin
                        w_key_held_nxt = 1'b0;
                        w_col_nxt      = r_cur_col + 2'd1;
                        w_dwell_nxt    = '0;
                        w_deb_nxt      = '0;
                        w_state_nxt    = SCAN;
                    end else begin
                        w_deb_nxt = r_deb + 1'b1;
                    end
                end else begin
                    w_deb_nxt = '0;
                end
            end
            default: w_state_nxt = SCAN;
        endcase

        if (kif.key_ack && r_key_valid) begin
            w_key_valid_nxt = 1'b0;
            w_overrun_nxt   = 1'b0;
        end

        // A same-cycle ack frees the slot, so the new key replaces the old one cleanly.
        if (w_accept) begin
            w_key_held_nxt = 1'b1;
            if (!r_key_valid || kif.key_ack) begin
                w_key_row_nxt   = r_cap_row;
                w_key_col_nxt   = r_cap_col;
                w_key_valid_nxt = 1'b1;
            end else begin
                w_overrun_nxt = 1'b1;
            end
        end
    end

    assign o_col_drive_n = r_col_drive_n;
    assign kif.key_row   = r_key_row;
    assign kif.key_col   = r_key_col;
    assign kif.key_valid = r_key_valid;
    assign kif.key_held  = r_key_held;
    assign kif.overrun   = r_overrun;
endmodule
